// File: rtl/instruction_fetch.sv
// Single-entry instruction fetch stage with redirect and misaligned-redirect halt.
// Optional registered predecode outputs are enabled by FETCH_PREDECODE_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
`ifdef FETCH_PREDECODE_EN
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [5:0]  out_funct,
    output logic [31:0] out_imm_sext,
    output logic        out_is_branch,
`endif
    output logic        fault
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        free;
    logic        redir_ok;
    logic        redir_bad;
    logic        take;

    assign imem_addr    = pc;
    assign out_pc_plus4 = out_pc + 32'd4;

    assign free      = !out_valid || out_ready;
    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign take      = !redirect_valid && free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
`ifdef FETCH_PREDECODE_EN
            out_opcode    <= '0;
            out_rs        <= '0;
            out_rt        <= '0;
            out_rd        <= '0;
            out_funct     <= '0;
            out_imm_sext  <= '0;
            out_is_branch <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    unique case (1'b1)
                        redir_ok: begin
                            pc        <= redirect_pc;
                            out_valid <= 1'b0;
                        end
                        redir_bad: begin
                            fault     <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= HALT;
                        end
                        take: begin
                            out_instr <= imem_data;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + 32'd4;
`ifdef FETCH_PREDECODE_EN
                            out_opcode    <= imem_data[31:26];
                            out_rs        <= imem_data[25:21];
                            out_rt        <= imem_data[20:16];
                            out_rd        <= imem_data[15:11];
                            out_funct     <= imem_data[5:0];
                            out_imm_sext  <= {{16{imem_data[15]}},
                                              imem_data[15:0]};
                            out_is_branch <= (imem_data[31:27] == 5'b00010);
`endif
                        end
                        default: ;
                    endcase
                end
                // Halted until reset: nothing moves.
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end

endmodule
